// File: rtl/gfx_src_sched.sv
// -----------------------------------------------------------------------------
// gfx_src_sched
//
// Purpose:
//   Arbitrates the single gfx pixel write stream (feeding the framebuffer /
//   fade writer) between two producers: the screen-clear generator and the
//   ADC XY sample stream.
//
//   After reset the scheduler kicks the clear generator, passes one full clear
//   pass through, waits a drain interval once the last clear pixel has left
//   the output register, and then grants the ADC stream. A clear_req pulse
//   while the ADC owns the stream queues a new clear pass; the switch happens
//   only once the output register is empty, so every transfer is a whole
//   pixel and nothing downstream ever sees a torn or changing pixel.
//
// Handshake (all pixel interfaces): a beat transfers on a rising clk edge
// where pvalid && pready are both high. A producer holds its beat stable
// until it transfers; the gfx output register does the same for downstream.
//
// Parameters:
//   FB_X_BITS    framebuffer x coordinate width
//   FB_Y_BITS    framebuffer y coordinate width
//   PIXEL_BITS   pixel color width
//   DRAIN_CYCLES idle cycles between the last clear pixel leaving and the ADC
//                grant (>= 1)
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clear_req           pulse; request a new clear pass
//   clr_start           one-cycle pulse; restarts the clear generator
//   clr_pvalid/pready   clear pixel handshake; clr_x/clr_y/clr_color payload,
//                       clr_last marks the final clear pixel
//   adc_pvalid/pready   ADC pixel handshake; adc_x/adc_y/adc_color payload
//   gfx_pvalid/pready   registered output handshake; gfx_x/gfx_y/gfx_color
//   adc_active          high while the ADC owns the stream
//   clear_done          one-cycle pulse when the drain interval completes
//   adc_drop_cnt        (GFX_SRC_SCHED_ADC_DROP_EN only) saturating count of
//                       ADC pixels dropped because the output was busy
//   state_dbg           current scheduler state (START/CLEAR/DRAIN/ADC)
//
// Build option:
//   GFX_SRC_SCHED_ADC_DROP_EN  when defined, the ADC stream is never
//   back-pressured by the output register: an ADC pixel offered while the
//   output is busy is dropped and counted in adc_drop_cnt. When undefined,
//   the ADC is back-pressured like the clear stream and adc_drop_cnt does
//   not exist.
// -----------------------------------------------------------------------------
module gfx_src_sched #(
    parameter int FB_X_BITS    = 10,
    parameter int FB_Y_BITS    = 9,
    parameter int PIXEL_BITS   = 12,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  clear_req,
    output logic                  clr_start,

    input  logic                  clr_pvalid,
    output logic                  clr_pready,
    input  logic [FB_X_BITS-1:0]  clr_x,
    input  logic [FB_Y_BITS-1:0]  clr_y,
    input  logic [PIXEL_BITS-1:0] clr_color,
    input  logic                  clr_last,

    input  logic                  adc_pvalid,
    output logic                  adc_pready,
    input  logic [FB_X_BITS-1:0]  adc_x,
    input  logic [FB_Y_BITS-1:0]  adc_y,
    input  logic [PIXEL_BITS-1:0] adc_color,

    output logic                  gfx_pvalid,
    input  logic                  gfx_pready,
    output logic [FB_X_BITS-1:0]  gfx_x,
    output logic [FB_Y_BITS-1:0]  gfx_y,
    output logic [PIXEL_BITS-1:0] gfx_color,

    output logic                  adc_active,
    output logic                  clear_done,
`ifdef GFX_SRC_SCHED_ADC_DROP_EN
    output logic [15:0]           adc_drop_cnt,
`endif
    output logic [1:0]            state_dbg
);

    // Drain counter must hold DRAIN_CYCLES itself.
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ADC   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;

    // Output register can take a new pixel this cycle.
    logic             free;
    logic             clr_accept;
    logic             adc_take;   // ADC handshake completed
    logic             adc_load;   // ADC pixel actually written into the output

    assign free      = !gfx_pvalid || gfx_pready;
    assign state_dbg = state_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // clr_last only matters on the beat that actually transfers.
                if (clr_accept && clr_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!gfx_pvalid && (cnt_q == CNT_W'(1))) begin
                    state_d = ST_ADC;
                end
            end
            ST_ADC: begin
                // With pend set no new ADC pixel can load, so waiting for the
                // output register to empty guarantees a pixel-boundary switch.
                if (pend_q && !gfx_pvalid) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (combinational from state and output register)
    // -------------------------------------------------------------------------
    always_comb begin
        clr_start  = 1'b0;
        clr_pready = 1'b0;
        adc_pready = 1'b0;
        adc_active = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_START: begin
                    clr_start = 1'b1;
                end
                ST_CLEAR: begin
                    clr_pready = free;
                end
                ST_ADC: begin
                    adc_active = 1'b1;
`ifdef GFX_SRC_SCHED_ADC_DROP_EN
                    adc_pready = !pend_q;
`else
                    adc_pready = !pend_q && free;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign clr_accept = clr_pready && clr_pvalid;
    assign adc_take   = adc_pready && adc_pvalid;
    assign adc_load   = adc_take && free;

    // -------------------------------------------------------------------------
    // Pending clear request. Only meaningful in ADC: a request during
    // START/CLEAR/DRAIN is already covered by the pass in progress. The flag
    // is registered, so a request arriving alongside an ADC accept does not
    // block that pixel; the grant closes from the next cycle on.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (state_q != ST_ADC || state_d == ST_START) begin
            pend_q <= 1'b0;
        end else if (clear_req) begin
            pend_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Drain counter. Loaded as the last clear pixel is accepted; counts only
    // while the output register is empty, so the interval is measured from
    // the moment that pixel has left, and a stalled downstream freezes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_CLEAR && state_d == ST_DRAIN) begin
            cnt_q <= CNT_W'(DRAIN_CYCLES);
        end else if (state_q == ST_DRAIN && !gfx_pvalid && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state_q == ST_DRAIN) && (state_d == ST_ADC);
        end
    end

    // -------------------------------------------------------------------------
    // Output register. The two accepts are mutually exclusive by state, and
    // the payload only changes on a load, so it is stable while stalled.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            gfx_pvalid <= 1'b0;
            gfx_x      <= '0;
            gfx_y      <= '0;
            gfx_color  <= '0;
        end else if (clr_accept) begin
            gfx_pvalid <= 1'b1;
            gfx_x      <= clr_x;
            gfx_y      <= clr_y;
            gfx_color  <= clr_color;
        end else if (adc_load) begin
            gfx_pvalid <= 1'b1;
            gfx_x      <= adc_x;
            gfx_y      <= adc_y;
            gfx_color  <= adc_color;
        end else if (gfx_pready) begin
            gfx_pvalid <= 1'b0;
        end
    end

`ifdef GFX_SRC_SCHED_ADC_DROP_EN
    // -------------------------------------------------------------------------
    // Dropped ADC pixels: handshake completed but the output register was
    // still holding an unaccepted pixel. Count restarts with every clear pass.
    // -------------------------------------------------------------------------
    logic adc_drop;
    assign adc_drop = adc_take && !free;

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_drop_cnt <= '0;
        end else if (state_q != ST_START && state_d == ST_START) begin
            adc_drop_cnt <= '0;
        end else if (adc_drop && adc_drop_cnt != 16'hFFFF) begin
            adc_drop_cnt <= adc_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gfx_src_sched.sv
// -----------------------------------------------------------------------------
// tb_gfx_src_sched
//
// Directed bench for gfx_src_sched. A clear-generator model and an ADC source
// model drive the two producer ports; every pixel that completes a handshake
// into the scheduler is pushed on exp_q (unless it is dropped), and a monitor
// pops and compares each pixel that leaves on the gfx port. The main process
// walks through reset, a full first pass, downstream stalls, clear requests
// in ADC and CLEAR, and reset mid-pass, checking control outputs at
// hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_gfx_src_sched;

    localparam int XB = 10;
    localparam int YB = 9;
    localparam int PB = 12;
    localparam int DR = 8;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          clear_req;
    logic          clr_start;
    logic          clr_pvalid;
    logic          clr_pready;
    logic [XB-1:0] clr_x;
    logic [YB-1:0] clr_y;
    logic [PB-1:0] clr_color;
    logic          clr_last;
    logic          adc_pvalid;
    logic          adc_pready;
    logic [XB-1:0] adc_x;
    logic [YB-1:0] adc_y;
    logic [PB-1:0] adc_color;
    logic          gfx_pvalid;
    logic          gfx_pready;
    logic [XB-1:0] gfx_x;
    logic [YB-1:0] gfx_y;
    logic [PB-1:0] gfx_color;
    logic          adc_active;
    logic          clear_done;
    logic [1:0]    state_dbg;
`ifdef GFX_SRC_SCHED_ADC_DROP_EN
    logic [15:0]   adc_drop_cnt;
`endif

    gfx_src_sched #(
        .FB_X_BITS(XB), .FB_Y_BITS(YB), .PIXEL_BITS(PB), .DRAIN_CYCLES(DR)
    ) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .clr_start(clr_start),
        .clr_pvalid(clr_pvalid), .clr_pready(clr_pready), .clr_x(clr_x),
        .clr_y(clr_y), .clr_color(clr_color), .clr_last(clr_last),
        .adc_pvalid(adc_pvalid), .adc_pready(adc_pready), .adc_x(adc_x),
        .adc_y(adc_y), .adc_color(adc_color),
        .gfx_pvalid(gfx_pvalid), .gfx_pready(gfx_pready), .gfx_x(gfx_x),
        .gfx_y(gfx_y), .gfx_color(gfx_color),
        .adc_active(adc_active), .clear_done(clear_done),
`ifdef GFX_SRC_SCHED_ADC_DROP_EN
        .adc_drop_cnt(adc_drop_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------------------------------------------------- scoreboard
    logic [XB+YB+PB-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_done = 0;
    int adc_left = 0;
    int adc_idx = 0;

    // Clear pass: 4 pixels, the 4th is (3,7,0xF00) and carries clr_last.
    logic [XB-1:0] ctx[4] = '{10'd0, 10'd1, 10'd2, 10'd3};
    logic [YB-1:0] cty[4] = '{9'd1, 9'd3, 9'd5, 9'd7};
    logic [PB-1:0] ctc[4] = '{12'h000, 12'h0F0, 12'h00F, 12'hF00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for adc_active at negedges; n = number of negedges waited.
    task automatic wait_adc_active(input string name, output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (adc_active) begin
                n = k;
                break;
            end
        end
        chk({name, "_adc_seen"}, 32'(n > 0), 32'd1);
    endtask

    task automatic wait_clr_start(input string name);
        int found;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clr_start) begin
                found = 1;
                break;
            end
        end
        chk({name, "_start_seen"}, 32'(found), 32'd1);
    endtask

    // ------------------------------------------------ clear generator model
    initial begin : clr_src
        int   idx;
        logic hs, st, rs;
        idx = 0;
        clr_pvalid = 1'b0;
        clr_x = '0; clr_y = '0; clr_color = '0; clr_last = 1'b0;
        forever begin
            @(negedge clk);
            rs = reset;
            st = clr_start;
            hs = clr_pvalid && clr_pready && !reset;
            if (hs) exp_q.push_back({clr_x, clr_y, clr_color});
            @(posedge clk);
            #1;
            if (rs) begin
                idx = 0;
                clr_pvalid = 1'b0;
            end else if (st) begin
                idx = 0;
                clr_pvalid = 1'b1;
            end else if (hs) begin
                idx++;
                if (idx >= 4) begin
                    idx = 0;
                    clr_pvalid = 1'b0;
                end
            end
            clr_x = ctx[idx];
            clr_y = cty[idx];
            clr_color = ctc[idx];
            clr_last = (idx == 3);
        end
    end

    // ----------------------------------------------------- ADC source model
    initial begin : adc_src
        logic hs, fr;
        adc_pvalid = 1'b0;
        adc_x = '0; adc_y = '0; adc_color = '0;
        forever begin
            @(negedge clk);
            hs = adc_pvalid && adc_pready && !reset;
            fr = !gfx_pvalid || gfx_pready;
            // A beat taken while the output is busy can only be a drop.
            if (hs && fr) exp_q.push_back({adc_x, adc_y, adc_color});
            @(posedge clk);
            #1;
            if (hs) begin
                adc_left--;
                adc_idx++;
            end
            adc_pvalid = (adc_left > 0);
            adc_x = adc_idx[XB-1:0];
            adc_y = YB'(adc_idx + 100);
            adc_color = 12'hA00 | {4'h0, adc_idx[7:0]};
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        logic [XB+YB+PB-1:0] e;
        forever begin
            @(negedge clk);
            if (clr_start) n_start++;
            if (clear_done) n_done++;
            if (gfx_pvalid === 1'b1 && gfx_pready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: actual=%0h required=none",
                             {gfx_x, gfx_y, gfx_color});
                end else begin
                    e = exp_q.pop_front();
                    chk("gfx_pixel", 32'({gfx_x, gfx_y, gfx_color}), 32'(e));
                end
            end
        end
    end

    // ------------------------------------------------------------- watchdog
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    // ----------------------------------------------------------------- main
    initial begin : main
        int n, s0, d0;
        int found;
        reset = 1'b1;
        clear_req = 1'b0;
        gfx_pready = 1'b1;

        // ---- reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_gfx_pvalid", 32'(gfx_pvalid), 32'd0);
        chk("rst_gfx_data", 32'({gfx_x, gfx_y, gfx_color}), 32'd0);
        chk("rst_adc_active", 32'(adc_active), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_clr_start", 32'(clr_start), 32'd0);
        chk("rst_clr_pready", 32'(clr_pready), 32'd0);
        chk("rst_adc_pready", 32'(adc_pready), 32'd0);

        // ---- first pass after reset release
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_clr_start_c1", 32'(clr_start), 32'd1);
        @(negedge clk);
        chk("t1_clr_start_c2", 32'(clr_start), 32'd0);
        chk("t1_gfx_idle", 32'(gfx_pvalid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_pix_valid", 32'(gfx_pvalid), 32'd1);
            chk("t1_pix_x", 32'(gfx_x), 32'(ctx[i]));
        end
        @(negedge clk);
        chk("t1_out_empty", 32'(gfx_pvalid), 32'd0);
        chk("t1_adc_early", 32'(adc_active), 32'd0);
        wait_adc_active("t1", n);
        chk("t1_drain_len", 32'(n), 32'(DR));
        chk("t1_clear_done", 32'(clear_done), 32'd1);
        @(negedge clk);
        chk("t1_clear_done_pulse", 32'(clear_done), 32'd0);
        tick();
        chk("t1_done_count", 32'(n_done), 32'd1);
        chk("t1_start_count", 32'(n_start), 32'd1);

        // ---- ADC stream passes through
        adc_left = 1000;
        repeat (8) tick();

        // ---- clear_req in ADC while downstream stalls
        gfx_pready = 1'b0;
        tick();
        tick();
        s0 = n_start;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        @(negedge clk);
        chk("t3_adc_pready_drop", 32'(adc_pready), 32'd0);
        chk("t3_held", 32'(gfx_pvalid), 32'd1);
        repeat (3) tick();
        chk("t3_no_start_yet", 32'(n_start - s0), 32'd0);
        chk("t3_still_adc", 32'(adc_active), 32'd1);

        // Single-step downstream until clear pixel (3,7,0xF00) is held.
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gfx_pvalid && !adc_active && gfx_x == 10'd3 && gfx_color == 12'hF00) begin
                found = 1;
                break;
            end
            tick();
            gfx_pready = 1'b1;
            tick();
            gfx_pready = 1'b0;
        end
        chk("t2_target_seen", 32'(found), 32'd1);
        chk("t3_one_start", 32'(n_start - s0), 32'd1);

        // ---- stall for 5 cycles with the pixel held
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t2_stall_valid", 32'(gfx_pvalid), 32'd1);
            chk("t2_stall_x", 32'(gfx_x), 32'd3);
            chk("t2_stall_y", 32'(gfx_y), 32'd7);
            chk("t2_stall_color", 32'(gfx_color), 32'hF00);
            chk("t2_stall_clr_pready", 32'(clr_pready), 32'd0);
        end
        tick();
        gfx_pready = 1'b1;
        @(negedge clk);
        chk("t2_taken", 32'(gfx_pvalid && gfx_pready), 32'd1);
        @(negedge clk);
        chk("t2_empty_after", 32'(gfx_pvalid), 32'd0);
        d0 = n_done;
        wait_adc_active("t2", n);
        chk("t2_drain_len", 32'(n), 32'(DR));
        tick();
        chk("t2_done_count", 32'(n_done - d0), 32'd1);
        repeat (6) tick();

        // ---- clear_req during CLEAR is ignored
        s0 = n_start;
        d0 = n_done;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_clr_start("t4");
        tick();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_adc_active("t4", n);
        repeat (12) tick();
        chk("t4_one_start", 32'(n_start - s0), 32'd1);
        chk("t4_one_done", 32'(n_done - d0), 32'd1);
        chk("t4_still_adc", 32'(adc_active), 32'd1);

        // ---- reset mid-clear with a pixel held
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_clr_start("t5");
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gfx_pvalid && !adc_active) begin
                found = 1;
                break;
            end
        end
        chk("t5_clear_pixel_seen", 32'(found), 32'd1);
        tick();
        reset = 1'b1;
        gfx_pready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_rst_clr_start", 32'(clr_start), 32'd0);
        chk("t5_rst_clr_pready", 32'(clr_pready), 32'd0);
        chk("t5_rst_adc_pready", 32'(adc_pready), 32'd0);
        tick();
        reset = 1'b0;
        gfx_pready = 1'b1;
        @(negedge clk);
        chk("t5_pvalid_cleared", 32'(gfx_pvalid), 32'd0);
        chk("t5_restart", 32'(clr_start), 32'd1);
        chk("t5_adc_off", 32'(adc_active), 32'd0);
        wait_adc_active("t5", n);
        repeat (6) tick();

`ifdef GFX_SRC_SCHED_ADC_DROP_EN
        // ---- drop mode: 3 beats into a stalled output
        adc_left = 0;
        repeat (6) tick();
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        gfx_pready = 1'b0;
        tick();
        adc_left = 3;
        repeat (6) tick();
        @(negedge clk);
        chk("t6_drop_cnt", 32'(adc_drop_cnt), 32'd2);
        chk("t6_held_valid", 32'(gfx_pvalid), 32'd1);
        chk("t6_one_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0)
            chk("t6_held_pixel", 32'({gfx_x, gfx_y, gfx_color}), 32'(exp_q[0]));
        tick();
        gfx_pready = 1'b1;
        repeat (4) tick();
`endif

        // ---- end: everything expected has come out
        adc_left = 0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (exp_q.size() == 0 && !gfx_pvalid) begin
                found = 1;
                break;
            end
        end
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gfx_src_sched.md
Name: gfx_src_sched

Overview:
- Schedules the shared gfx pixel write stream that feeds the framebuffer/fade writer between two producers: the screen-clear generator and the ADC XY sample stream.
- On reset it runs one full clear pass, waits a drain interval, then grants the ADC. It re-runs a clear on request.
- All switching happens on pixel boundaries. The output is a registered valid/ready stage, so downstream never sees a torn or changing pixel.

Parameters:
- FB_X_BITS, 10, framebuffer x coordinate width
- FB_Y_BITS, 9, framebuffer y coordinate width
- PIXEL_BITS, 12, pixel color width
- DRAIN_CYCLES, 8, idle cycles between the last clear pixel leaving and ADC grant (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clear_req  in  1  pulse; request a new clear pass
- clr_start  out  1  one-cycle pulse; restarts the clear generator
- clr_pvalid  in  1  clear pixel valid
- clr_pready  out  1  clear pixel accepted
- clr_x  in  FB_X_BITS  clear pixel x
- clr_y  in  FB_Y_BITS  clear pixel y
- clr_color  in  PIXEL_BITS  clear pixel color
- clr_last  in  1  qualifies the final clear pixel
- adc_pvalid  in  1  ADC pixel valid
- adc_pready  out  1  ADC pixel accepted
- adc_x  in  FB_X_BITS  ADC pixel x
- adc_y  in  FB_Y_BITS  ADC pixel y
- adc_color  in  PIXEL_BITS  ADC pixel color
- gfx_pvalid  out  1  output pixel valid
- gfx_pready  in  1  downstream ready
- gfx_x  out  FB_X_BITS  output pixel x
- gfx_y  out  FB_Y_BITS  output pixel y
- gfx_color  out  PIXEL_BITS  output pixel color
- adc_active  out  1  state is ADC
- clear_done  out  1  one-cycle pulse when the drain interval completes

Behaviour:
- Output stage
  - Single register; free when !gfx_pvalid || gfx_pready.
  - Source accept = grant && free && src_pvalid; on accept, load x/y/color and set gfx_pvalid.
  - gfx_pvalid clears when gfx_pready=1 and nothing is loaded that cycle.
  - gfx_x/y/color hold stable while gfx_pvalid && !gfx_pready.
  - Latency: source accept to gfx_pvalid is 1 cycle.
- Ready outputs
  - clr_pready = (state==CLEAR) && free.
  - adc_pready = (state==ADC) && !pend && free.
  - Both are combinational from state and the output stage. Never both high.
- States
  - START: clr_start=1 for exactly one cycle -> CLEAR.
  - CLEAR: grant clear. On accept with clr_last=1 -> DRAIN; counter loads DRAIN_CYCLES.
  - DRAIN: no grant. Counter decrements only while gfx_pvalid=0. At counter==1 with gfx_pvalid=0 -> ADC and pulse clear_done.
  - ADC: grant ADC. clear_req (or a pending latch) sets pend and stops the ADC grant. Once gfx_pvalid=0 -> START and clear pend.
- pend flag
  - clear_req arriving in START/CLEAR/DRAIN is ignored; the pass in progress already satisfies it.
  - clear_req in ADC on the same cycle as an ADC accept: that pixel is still accepted; pend takes effect next cycle.
- Reset values
  - state=START (so clr_start pulses in the first cycle after reset deasserts).
  - gfx_pvalid=0, gfx_x/y/color=0, adc_active=0, clear_done=0, pend=0, counter=0.
  - During reset: clr_start=0, clr_pready=0, adc_pready=0.
- Reset mid-operation discards any held pixel and restarts from START.
- clr_last is sampled only on an accepted clear pixel.
- gfx_pready=0 indefinitely: the scheduler stalls in place and the counter does not advance.

Optional Feature:
- Macro: GFX_SRC_SCHED_ADC_DROP_EN.
- When defined:
  - In ADC state, adc_pready = !pend (independent of free).
  - An ADC pixel arriving while the output stage is not free is dropped.
  - Adds output adc_drop_cnt, 16 bits: saturating drop count, cleared on reset and on entry to START.
- When undefined: ADC is back-pressured as described above, and the adc_drop_cnt port does not exist.

Test Plan:
- Reset release, clear model emits 4 pixels with last on the 4th, gfx_pready=1:
  - clr_start pulses at cycle 1; 4 gfx pixels appear, each 1 cycle after accept.
  - adc_active rises DRAIN_CYCLES(8) cycles after the 4th pixel leaves; clear_done pulses once.
- gfx_pready held 0 for 5 cycles with a pixel (x=3,y=7,color=0xF00) pending:
  - gfx outputs stable and clr_pready=0 for all 5 cycles; pixel accepted on the cycle ready returns.
- ADC state, continuous adc_pvalid, clear_req pulsed with gfx_pready=0:
  - adc_pready drops next cycle; START entered only after the held pixel is accepted.
  - No ADC pixel is seen after the clr_start pulse.
- clear_req pulsed during CLEAR:
  - Ignored; exactly one clr_start pulse; ADC granted after the single drain interval.
- Reset asserted with gfx_pvalid=1 mid-clear:
  - gfx_pvalid=0 next cycle; clr_start re-pulses after reset deasserts.
- With GFX_SRC_SCHED_ADC_DROP_EN, ADC state, gfx_pready=0, 3 adc_pvalid beats:
  - First beat is held on the output; the other 2 are dropped; adc_drop_cnt=2.
